uart_tx_core: RTL and testbench

UART transmitter, the transmit-side counterpart to the system's oversampled UART receiver. It accepts a parallel word on a single-cycle valid strobe and serialises it as start bit, DATA_WIDTH data bits (LSB first), an optional parity bit and a stop bit. Each bit is held for pre_scale cycles of clk, so TX and RX share one clock and one prescale setting. It sits in the UART block beside the receiver and is fed by the system controller or FIFO.

---
 rtl/uart_tx_core_if.sv | 35 +++
 rtl/uart_tx_core.sv | 151 +++++++++++++++
 tb/tb_uart_tx_core.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_core_if.sv
// Transmit-side handshake bundle for uart_tx_core.
// Optional macro UART_TX_TWO_STOP_EN adds the stop2 request bit.
interface uart_tx_core_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_type;
    logic [5:0]            pre_scale;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop2;
`endif
    logic                  TX_OUT;
    logic                  busy;
    logic                  tx_done;

    // Requester side (controller / FIFO)
    modport master (
        output P_DATA, data_valid, par_en, par_type, pre_scale,
`ifdef UART_TX_TWO_STOP_EN
        output stop2,
`endif
        input  TX_OUT, busy, tx_done
    );

    // Transmitter side
    modport slave (
        input  P_DATA, data_valid, par_en, par_type, pre_scale,
`ifdef UART_TX_TWO_STOP_EN
        input  stop2,
`endif
        output TX_OUT, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Each bit lasts pre_scale clk cycles (0 means 64). All frame settings are latched on accept.
// Optional macro UART_TX_TWO_STOP_EN adds a stop2 request giving a double-length stop bit.
module uart_tx_core #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_core_if.slave tx
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic                  par_en_q, par_en_d;
    logic                  par_type_q, par_type_d;
    logic [5:0]            pre_q, pre_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  tx_done;
    logic                  accept;
    logic                  bit_end;
    logic                  last_data;
    logic                  last_stop;
    logic [15:0]           data_ext;

    assign accept    = (state_q == StIdle) && tx.data_valid;
    // pre_q == 0 wraps to 63 here, so the counter runs the full 64 cycles
    assign bit_end   = (edge_cnt_q == pre_q - 6'd1);
    assign last_data = (bit_cnt_q == 4'(DATA_WIDTH - 1));

`ifdef UART_TX_TWO_STOP_EN
    logic stop2_q, stop2_d;
    logic stop_cnt_q, stop_cnt_d;

    assign last_stop = !stop2_q || stop_cnt_q;
`else
    assign last_stop = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every non-idle state advances on a bit boundary
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (tx.data_valid) state_d = StStart;
            StStart:  if (bit_end) state_d = StData;
            StData:   if (bit_end && last_data) state_d = par_en_q ? StParity : StStop;
            StParity: if (bit_end) state_d = StStop;
            StStop:   if (bit_end && last_stop) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Shadow registers and bit/edge counters
    always_comb begin
        shadow_d   = shadow_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        pre_d      = pre_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
`endif
        if (accept) begin
            shadow_d   = tx.P_DATA;
            par_en_d   = tx.par_en;
            par_type_d = tx.par_type;
            pre_d      = tx.pre_scale;
            edge_cnt_d = 6'd0;
            bit_cnt_d  = 4'd0;
`ifdef UART_TX_TWO_STOP_EN
            stop2_d    = tx.stop2;
            stop_cnt_d = 1'b0;
`endif
        end else if (state_q != StIdle) begin
            edge_cnt_d = bit_end ? 6'd0 : edge_cnt_q + 6'd1;
            if (state_q == StData && bit_end) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
`ifdef UART_TX_TWO_STOP_EN
            if (state_q == StStop && bit_end) begin
                stop_cnt_d = 1'b1;
            end
`endif
        end
    end

    // Outputs: line level follows the state being entered so TX_OUT is registered
    always_comb begin
        data_ext = 16'(shadow_d);
        tx_d     = 1'b1;
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_ext[bit_cnt_d];
            StParity: tx_d = par_type_d ? ~^shadow_d : ^shadow_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d  = (state_d != StIdle);
        tx_done = (state_q == StStop) && bit_end && last_stop;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            pre_q      <= 6'd0;
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= 4'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
`endif
        end else begin
            shadow_q   <= shadow_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            pre_q      <= pre_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
`endif
        end
    end

    assign tx.TX_OUT  = tx_q;
    assign tx.busy    = busy_q;
    assign tx.tx_done = tx_done;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: expected line levels come from a frame model
// built as a list of bit levels, each expanded to P cycles.
module tb_uart_tx_core;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_tx_core_if #(.DATA_WIDTH(DW)) tx_if ();

    uart_tx_core #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx    (tx_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_lv[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame as a list of line levels, one entry per bit period
    function automatic void build_frame(input logic [DW-1:0] d, input bit pe, input bit pt,
                                        input bit s2);
        exp_lv.delete();
        exp_lv.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_lv.push_back(d[i]);
        if (pe) exp_lv.push_back(bit'(($countones(d) + int'(pt)) % 2));
        exp_lv.push_back(1'b1);
        if (s2) exp_lv.push_back(1'b1);
    endfunction

    task automatic set_stop2(input bit v);
`ifdef UART_TX_TWO_STOP_EN
        tx_if.stop2 = v;
`else
        if (v) $display("[TB] stop2 ignored in single-stop build");
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, tx_if.busy, 1'b0);
        check({tag, "_line"}, tx_if.TX_OUT, 1'b1);
        check({tag, "_done"}, tx_if.tx_done, 1'b0);
    endtask

    // Sends one frame and checks every cycle; inputs are scrambled while busy and
    // data_valid is pulsed at random (and forced at collide_at with 0x3C)
    task automatic run_frame(input logic [DW-1:0] d, input bit pe, input bit pt, input bit s2,
                             input logic [5:0] ps, input int collide_at, input string tag);
        int p;
        int total;
        p = (ps == 6'd0) ? 64 : int'(ps);
        build_frame(d, pe, pt, s2);
        total = exp_lv.size() * p;
        @(negedge clk);
        check_idle({tag, "_pre"});
        tx_if.P_DATA     = d;
        tx_if.par_en     = pe;
        tx_if.par_type   = pt;
        tx_if.pre_scale  = ps;
        set_stop2(s2);
        tx_if.data_valid = 1'b1;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            check({tag, "_line"}, tx_if.TX_OUT, exp_lv[k / p]);
            check({tag, "_busy"}, tx_if.busy, 1'b1);
            check({tag, "_done"}, tx_if.tx_done, (k == total - 1) ? 1'b1 : 1'b0);
            tx_if.P_DATA     = DW'($urandom);
            tx_if.par_en     = 1'($urandom);
            tx_if.par_type   = 1'($urandom);
            tx_if.pre_scale  = 6'($urandom);
            tx_if.data_valid = ($urandom_range(0, 7) == 0);
            if (k == collide_at) begin
                tx_if.P_DATA     = DW'(8'h3C);
                tx_if.data_valid = 1'b1;
            end
        end
        @(negedge clk);
        check_idle({tag, "_end"});
        tx_if.data_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [5:0]    ps;
        bit            pe;
        bit            pt;
        bit            s2;
        int            sel;

        tx_if.P_DATA     = '0;
        tx_if.data_valid = 1'b0;
        tx_if.par_en     = 1'b0;
        tx_if.par_type   = 1'b0;
        tx_if.pre_scale  = 6'd0;
        set_stop2(1'b0);

        // Reset and quiet idle
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("in_reset");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_idle("reset_idle");
        end

        // Directed frames
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 6'd8, -1, "even_a5");
        run_frame(8'h00, 1'b1, 1'b1, 1'b0, 6'd16, -1, "odd_00");
        run_frame(8'h00, 1'b0, 1'b1, 1'b0, 6'd16, -1, "nopar_00");
        run_frame(DW'($urandom), 1'b1, 1'($urandom), 1'b0, 6'd0, -1, "ps0");
        run_frame(8'hFF, 1'b1, 1'b0, 1'b0, 6'd1, -1, "ps1");

        // Collision mid-frame, then the rejected word sent properly
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 6'd8, 40, "collide");
        run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 6'd8, -1, "after_collide");

        // Randomized frames
        for (int n = 0; n < 12; n++) begin
            d   = DW'($urandom);
            pe  = 1'($urandom);
            pt  = 1'($urandom);
`ifdef UART_TX_TWO_STOP_EN
            s2  = 1'($urandom);
`else
            s2  = 1'b0;
`endif
            sel = $urandom_range(0, 3);
            ps  = (sel == 0) ? 6'd8 : (sel == 1) ? 6'd16 : (sel == 2) ? 6'd32
                : 6'($urandom_range(1, 63));
            run_frame(d, pe, pt, s2, ps, -1, "rand");
        end

        // Abort at data bit 4
        d = DW'($urandom);
        build_frame(d, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        tx_if.P_DATA     = d;
        tx_if.par_en     = 1'b1;
        tx_if.par_type   = 1'b0;
        tx_if.pre_scale  = 6'd8;
        set_stop2(1'b0);
        tx_if.data_valid = 1'b1;
        @(negedge clk);
        tx_if.data_valid = 1'b0;
        repeat (5 * 8 + 2) @(negedge clk);
        check("abort_bit4", tx_if.TX_OUT, exp_lv[5]);
        check("abort_busy_pre", tx_if.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_line", tx_if.TX_OUT, 1'b1);
        check("abort_busy", tx_if.busy, 1'b0);
        check("abort_done", tx_if.tx_done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle("post_abort");
        end
        run_frame(8'h5A, 1'b1, 1'b1, 1'b0, 6'd16, -1, "recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
